// File: rtl/aud_pwm_capture_if.sv
// Sample-memory write port of the PWM audio recorder.
//   mem_we    : one-clk write strobe
//   mem_addr  : write address
//   mem_wdata : recovered duty value
// master = recorder (drives the port), slave = sample memory.
interface aud_pwm_capture_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/aud_pwm_capture.sv
// Audio PWM recorder. Samples a synchronised PWM line once per tick, measures
// the high time of each 2^DATA_WIDTH-tick frame and writes the recovered duty
// (high ticks - 1, floored at 0) to sample memory.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   pwm_in    : asynchronous PWM input (2-flop synchronised)
//   start     : level, begin/restart a recording from IDLE/DONE
//   stop      : level, abort an ARM/CAPTURE recording
//   mem       : write port (mem_we / mem_addr / mem_wdata)
//   rec_len   : samples written in the current/last recording
//   busy      : ARM or CAPTURE
//   done      : DONE
module aud_pwm_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int MAX_LEN    = 190000,
  parameter int TICK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  input  logic                  start,
  input  logic                  stop,
  aud_pwm_capture_if.master     mem,
  output logic [ADDR_WIDTH-1:0] rec_len,
  output logic                  busy,
  output logic                  done
);
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ADDR_WIDTH;
  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(TICK_DIV - 1);
  localparam logic [AW-1:0]   LEN_LAST = AW'(MAX_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic          pwm_m_q, pwm_m_d, pwm_s_q, pwm_s_d, prev_q, prev_d;
  logic [DW-1:0] frame_cnt_q, frame_cnt_d;
  logic [DW:0]   high_cnt_q, high_cnt_d;   // 0..2^DW needs one extra bit
  logic [AW-1:0] rec_len_q, rec_len_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          tick;
  logic [DW:0]   high_nxt;

  always_comb begin
    state_d     = state_q;
    pwm_m_d     = pwm_in;
    pwm_s_d     = pwm_m_q;
    prev_d      = prev_q;
    frame_cnt_d = frame_cnt_q;
    high_cnt_d  = high_cnt_q;
    rec_len_d   = rec_len_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + DIVW'(1);
    high_nxt = high_cnt_q + {{DW{1'b0}}, pwm_s_q};

    // Edge history tracks the line in every state so ARM only fires on a
    // genuine low->high transition, never on a line that was already high.
    if (tick) prev_d = pwm_s_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ARM;
          rec_len_d = '0;
          addr_d    = '0;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick && pwm_s_q && !prev_q) begin
          // The edge tick itself is frame position 0 and is high.
          state_d     = S_CAPTURE;
          frame_cnt_d = DW'(1);
          high_cnt_d  = (DW+1)'(1);
        end
      end
      S_CAPTURE: begin
        if (tick && (frame_cnt_q == '1)) begin
          // Closing tick wins over stop: the frame is still written.
          we_d        = 1'b1;
          addr_d      = rec_len_q;
          // Low bits of high-1 are exact for 1..2^DW; zero high clamps to 0.
          wdata_d     = (high_nxt == '0) ? '0 : high_nxt[DW-1:0] - DW'(1);
          rec_len_d   = rec_len_q + AW'(1);
          frame_cnt_d = '0;
          high_cnt_d  = '0;
          if (stop || (rec_len_q == LEN_LAST)) state_d = S_DONE;
        end else if (stop) begin
          state_d = S_DONE;
        end else if (tick) begin
          frame_cnt_d = frame_cnt_q + DW'(1);
          high_cnt_d  = high_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      pwm_m_q     <= 1'b0;
      pwm_s_q     <= 1'b0;
      prev_q      <= 1'b0;
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
      rec_len_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pwm_m_q     <= pwm_m_d;
      pwm_s_q     <= pwm_s_d;
      prev_q      <= prev_d;
      frame_cnt_q <= frame_cnt_d;
      high_cnt_q  <= high_cnt_d;
      rec_len_q   <= rec_len_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rec_len       = rec_len_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule
